// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared FIFO-control types and defaults for fifo_wr_arbiter and the later read-side schedulers.
package fifo_ctrl_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 1;
  localparam int BURST_MAX_DEF = 8;
  localparam int STALL_MAX_DEF = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle around fifo_wr_arbiter; stall_err exists only with FIFO_ARB_TIMEOUT_EN.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = fifo_ctrl_pkg::NUM_REQ_DEF,
  parameter int DATA_W  = fifo_ctrl_pkg::DATA_W_DEF
);
  import fifo_ctrl_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         ack;
  logic [$clog2(NUM_REQ)-1:0] owner;
  logic                       busy;
  logic                       fifo_wr_en;
  logic [DATA_W-1:0]          fifo_din;
  logic                       fifo_full;
`ifdef FIFO_ARB_TIMEOUT_EN
  logic                       stall_err;

  modport master (output req, req_data, fifo_full,
                  input  gnt, ack, owner, busy, fifo_wr_en, fifo_din, stall_err);
  modport slave  (input  req, req_data, fifo_full,
                  output gnt, ack, owner, busy, fifo_wr_en, fifo_din, stall_err);
`else
  modport master (output req, req_data, fifo_full,
                  input  gnt, ack, owner, busy, fifo_wr_en, fifo_din);
  modport slave  (input  req, req_data, fifo_full,
                  output gnt, ack, owner, busy, fifo_wr_en, fifo_din);
`endif

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin first-set-bit search starting at rr_ptr, wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest set bit is the last write.
  always_comb begin
    int j;
    pick = '0;
    idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        pick    = '0;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of the FIFO write port. Optional stall timeout: FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
`ifdef FIFO_ARB_TIMEOUT_EN
  , parameter int STALL_MAX = STALL_MAX_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] gnt_q, pick, ack_c;
  logic [IDX_W-1:0]   owner_q, rr_ptr, pick_idx;
  logic [CNT_W-1:0]   burst_cnt;
  logic [DATA_W-1:0]  din_c;
  logic               own_req, wr, exit_burst, timeout;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .idx    (pick_idx)
  );

  assign own_req    = bus.req[owner_q];
  assign wr         = (state == ARB_BURST) && own_req && !bus.fifo_full;
  assign exit_burst = (state == ARB_BURST) &&
                      (!own_req || (wr && burst_cnt == CNT_W'(BURST_MAX - 1)) || timeout);

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int SW = $clog2(STALL_MAX + 1);
  logic [SW-1:0] stall_cnt;
  logic          stalling;

  assign stalling = (state == ARB_BURST) && own_req && bus.fifo_full;
  assign timeout  = stalling && (stall_cnt == SW'(STALL_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt     <= '0;
      bus.stall_err <= 1'b0;
    end else begin
      bus.stall_err <= timeout;
      stall_cnt     <= (exit_burst || !stalling) ? '0 : stall_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (|bus.req)  state_nxt = ARB_BURST;
      ARB_BURST: if (exit_burst) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (|bus.req) begin
        gnt_q   <= pick;
        owner_q <= pick_idx;
      end
    end else if (exit_burst) begin
      gnt_q     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end else if (wr) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Data mux is masked by wr so fifo_din reads zero whenever nothing is written.
  always_comb begin
    ack_c = '0;
    din_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr && owner_q == IDX_W'(i)) begin
        ack_c[i] = 1'b1;
        din_c    = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.ack        = ack_c;
  assign bus.fifo_din   = din_c;
  assign bus.fifo_wr_en = wr;
  assign bus.busy       = (state == ARB_BURST);
  assign bus.gnt        = gnt_q;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=1, BURST_MAX=8); timeout case under FIFO_ARB_TIMEOUT_EN.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cnt [4];

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(1)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(1), .BURST_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Requester i presents 1,0,1,0,... advancing one datum per ack it has seen.
  task automatic drive_data();
    for (int i = 0; i < 4; i++) bus.req_data[i] = (cnt[i] % 2 == 0);
  endtask

  // Advance one clock; returns at negedge+1 with requester data updated.
  task automatic nxt();
    logic [3:0] a;
    a = bus.ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (a[i]) cnt[i]++;
    drive_data();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_data();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_data();
    #2;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", bus.fifo_wr_en); end
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
    checks++; if (bus.fifo_din !== 1'b0) begin errors++; $display("FAIL reset_din got %b want 0", bus.fifo_din); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", bus.owner); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_burst();
    apply_reset();
    bus.req = 4'b0001;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt got %b want 0000", bus.gnt); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_idle_wr got %b want 0", bus.fifo_wr_en); end
    nxt();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", bus.gnt); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr%0d got %b want 1", k, bus.fifo_wr_en); end
      checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL single_ack%0d got %b want 0001", k, bus.ack); end
      checks++; if (bus.fifo_din !== ((k % 2) == 0)) begin errors++; $display("FAIL single_din%0d got %b want %b", k, bus.fifo_din, (k % 2) == 0); end
      nxt();
    end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_gap_gnt got %b want 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_gap_busy got %b want 0", bus.busy); end
    checks++; if (bus.fifo_din !== 1'b0) begin errors++; $display("FAIL single_gap_din got %b want 0", bus.fifo_din); end
    nxt();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_regnt got %b want 0001", bus.gnt); end
    bus.req = '0;
    #1;
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_drop_wr got %b want 0", bus.fifo_wr_en); end
    nxt();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_drop_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_g;
    apply_reset();
    bus.req = 4'b1111;
    nxt();
    for (int b = 0; b < 5; b++) begin
      exp_g = 4'b0001 << (b % 4);
      for (int k = 0; k < 8; k++) begin
        checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL rot_gnt b%0d k%0d got %b want %b", b, k, bus.gnt, exp_g); end
        checks++; if (bus.ack !== exp_g) begin errors++; $display("FAIL rot_ack b%0d k%0d got %b want %b", b, k, bus.ack, exp_g); end
        nxt();
      end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rot_gap b%0d got %b want 0", b, bus.busy); end
      nxt();
    end
    bus.req = '0;
    nxt();
  endtask

  task automatic test_drop();
    apply_reset();
    bus.req = 4'b0100;
    nxt();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL drop_ack%0d got %b want 0100", k, bus.ack); end
      checks++; if (bus.fifo_din !== ((k % 2) == 0)) begin errors++; $display("FAIL drop_din%0d got %b want %b", k, bus.fifo_din, (k % 2) == 0); end
      nxt();
    end
    bus.req = '0;
    #1;
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL drop_wr got %b want 0", bus.fifo_wr_en); end
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL drop_hold_gnt got %b want 0100", bus.gnt); end
    nxt();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL drop_clr_gnt got %b want 0000", bus.gnt); end
    checks++; if (cnt[2] !== 3) begin errors++; $display("FAIL drop_writes got %0d want 3", cnt[2]); end
    bus.req = 4'b1001;
    nxt();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL drop_rrptr_gnt got %b want 1000", bus.gnt); end
    checks++; if (bus.owner !== 2'd3) begin errors++; $display("FAIL drop_rrptr_owner got %0d want 3", bus.owner); end
    bus.req = '0;
    nxt();
  endtask

  task automatic test_full_stall();
    apply_reset();
    bus.req = 4'b0001;
    nxt();
    for (int k = 0; k < 4; k++) nxt();
    bus.fifo_full = 1'b1;
    #1;
    for (int s = 0; s < 5; s++) begin
      checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr%0d got %b want 0", s, bus.fifo_wr_en); end
      checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL stall_ack%0d got %b want 0000", s, bus.ack); end
      checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL stall_gnt%0d got %b want 0001", s, bus.gnt); end
      nxt();
    end
    bus.fifo_full = 1'b0;
    #1;
    for (int k = 4; k < 8; k++) begin
      checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL stall_resume%0d got %b want 0001", k, bus.ack); end
      nxt();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_end_busy got %b want 0", bus.busy); end
    checks++; if (cnt[0] !== 8) begin errors++; $display("FAIL stall_total got %0d want 8", cnt[0]); end
    bus.req = '0;
    nxt();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.req = 4'b0001;
    nxt();
    for (int k = 0; k < 4; k++) nxt();
    checks++; if (bus.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL rstmid_w5 got %b want 1", bus.fifo_wr_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt got %b want 0000", bus.gnt); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr got %b want 0", bus.fifo_wr_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    bus.req = 4'b0100;
    nxt();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b want 0", bus.busy); end
    nxt();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL rstmid_regnt got %b want 0100", bus.gnt); end
    checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL rstmid_ack got %b want 0100", bus.ack); end
    bus.req = '0;
    nxt();
  endtask

`ifdef FIFO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    bus.req = 4'b0001;
    bus.fifo_full = 1'b1;
    nxt();
    for (int s = 0; s < 16; s++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL to_busy%0d got %b want 1", s, bus.busy); end
      checks++; if (bus.stall_err !== 1'b0) begin errors++; $display("FAIL to_err_early%0d got %b want 0", s, bus.stall_err); end
      nxt();
    end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL to_release got %b want 0000", bus.gnt); end
    checks++; if (bus.stall_err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", bus.stall_err); end
    nxt();
    checks++; if (bus.stall_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b want 0", bus.stall_err); end
    bus.req = '0;
    bus.fifo_full = 1'b0;
    nxt();
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_rotate();
    test_drop();
    test_full_stall();
    test_reset_mid();
`ifdef FIFO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's bit-serial FIFO (wr_en/din/full) between NUM_REQ requesters.
- A granted requester holds the port for a burst of up to BURST_MAX accepted writes, or until it drops its request.
- Sits directly in front of the FIFO write side. Requesters never drive the FIFO directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 1, write data width per requester (matches FIFO din width)
- BURST_MAX, 8, maximum accepted writes per grant (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester write request, level
- req_data  in  NUM_REQ*DATA_W  packed data, requester i at bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  registered one-hot grant
- ack  out  NUM_REQ  one-hot, high in cycles where owner's data is written to the FIFO
- owner  out  $clog2(NUM_REQ)  index of current grantee, valid when busy=1
- busy  out  1  high while in BURST
- fifo_wr_en  out  1  FIFO write enable
- fifo_din  out  DATA_W  FIFO write data
- fifo_full  in  1  FIFO full flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt=0, owner=0, rr_ptr=0, burst_cnt=0.
  - Combinational outputs then evaluate to fifo_wr_en=0, ack=0, busy=0, fifo_din=0.
  - Reset mid-burst aborts the burst; no partial-burst state is retained.
- FSM states:
  - IDLE: if req!=0, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ. Register gnt/owner and go to BURST. If req=0, stay in IDLE.
  - BURST: write cycle when req[owner]=1 and fifo_full=0.
    - fifo_wr_en=1, fifo_din=req_data slice[owner], ack[owner]=1, burst_cnt+1.
  - BURST exit: go to IDLE at the next edge when either:
    - req[owner]=0, or
    - a write occurs with burst_cnt==BURST_MAX-1.
  - On exit: gnt=0, burst_cnt=0, rr_ptr=(owner+1) mod NUM_REQ.
- Latency:
  - First write at the earliest one cycle after req rises in IDLE.
  - Exactly one IDLE cycle between consecutive bursts.
- Outputs:
  - fifo_wr_en, fifo_din and ack are combinational from registered state, req, req_data and fifo_full. No extra latency.
  - fifo_din=0 when fifo_wr_en=0.
- Full stall: fifo_full=1 in BURST gives fifo_wr_en=0 and ack=0. burst_cnt holds and the grant is retained.
- Requester contract: a requester sees its data consumed only on ack. It presents the next datum in the cycle after ack.
- Non-owner req changes during BURST have no effect until the next IDLE.
- Widths: burst_cnt is $clog2(BURST_MAX+1) bits and never exceeds BURST_MAX-1 while registered.

Optional Feature:
- Macro FIFO_ARB_TIMEOUT_EN.
- When defined:
  - Parameter STALL_MAX (default 16) is added, along with output stall_err (1 bit, reset 0).
  - A counter tracks consecutive BURST cycles with req[owner]=1 and fifo_full=1.
  - When it reaches STALL_MAX, the grant is released as a normal exit and stall_err pulses high for one cycle.
  - The counter clears on any write or exit.
- When undefined: no counter and no stall_err port; a full stall holds the grant indefinitely.

Decomposition:
- Shared package fifo_ctrl_pkg holds:
  - state typedef/localparams ARB_IDLE=1'b0, ARB_BURST=1'b1
  - default NUM_REQ, BURST_MAX and STALL_MAX constants
- Sub-module rr_pick (combinational): inputs req and rr_ptr; outputs one-hot pick and index. Reused by later read-side schedulers.

Test Plan:
- Reset, then req=4'b0001 with data alternating 1/0 and fifo_full=0:
  - gnt=0001 one cycle after req.
  - 8 consecutive acks with fifo_din following data.
  - gnt drops after the 8th ack; one IDLE cycle, then re-grant to requester 0.
- req=4'b1111 held with fifo_full=0: grants rotate 0→1→2→3→0. Each burst is exactly 8 writes, separated by one idle cycle.
- Requester 2 alone drops req after 3 acks: gnt clears the next edge, rr_ptr=3, 3 writes total.
- fifo_full=1 for 5 cycles mid-burst after write 4: no wr_en or ack during the stall. Writes resume and the burst ends after write 8 (total 8).
- rst_n asserted mid-burst at write 5: gnt=0, wr_en=0 immediately. After release with req=4'b0100, grant goes to requester 2.
- FIFO_ARB_TIMEOUT_EN, STALL_MAX=16, fifo_full held high during BURST: grant released after 16 stall cycles, stall_err high for one cycle.
